// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Round-robin arbiter and sequencer that shares one sequential W x W multiplier
// between up to N_REQ requesters.
//
// In IDLE the arbiter picks the winning requester and latches its operands.
// It then pulses the multiplier load for one cycle and waits for the
// multiplier's ready. The product is returned with a one-cycle done strobe to
// the requester that was served.
//
// Transaction sequence: IDLE -> LOAD -> WAIT -> DONE -> IDLE.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   req     in   [N_REQ]     per-requester request level
//   op_a    in   [N_REQ*W]   packed operand A, requester i uses [i*W +: W]
//   op_b    in   [N_REQ*W]   packed operand B, same packing
//   gnt     out  [N_REQ]     one-hot grant, LOAD through DONE
//   done    out  [N_REQ]     one-cycle completion pulse; res is valid with it
//   res     out  [2*W]       product, held until the next capture
//   busy    out              high whenever the FSM is not in IDLE
//   m_ld    out              multiplier load pulse (LOAD state)
//   m_a     out  [W]         multiplier operand A, stable from LOAD onwards
//   m_b     out  [W]         multiplier operand B, stable from LOAD onwards
//   m_res   in   [2*W]       multiplier result
//   m_rdy   in               multiplier result-valid
//   err     out              sticky timeout flag (only with MULT_ARB_TIMEOUT_EN)
//
// Optional feature, macro MULT_ARB_TIMEOUT_EN:
//   When the macro is defined, WAIT gives up after TIMEOUT cycles without
//   m_rdy. The arbiter returns a zero product, sets err, and still pulses done.
//   When the macro is undefined, WAIT waits for m_rdy indefinitely and the err
//   port does not exist.
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   op_a,
    input  logic [N_REQ*W-1:0]   op_b,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [2*W-1:0]       res,
    output logic                 busy,
    output logic                 m_ld,
    output logic [W-1:0]         m_a,
    output logic [W-1:0]         m_b,
    input  logic [2*W-1:0]       m_res,
    input  logic                 m_rdy
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [W-1:0]     m_a_q, m_a_d;
    logic [W-1:0]     m_b_q, m_b_d;
    logic [2*W-1:0]   res_q, res_d;

    // Arbitration results (combinational, only acted on in IDLE)
    logic             found;
    logic [IW-1:0]    win;
    logic [IW-1:0]    cand;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [N_REQ-1:0] idx_oh;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic [31:0]      unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // ------------------------------------------------------------------
    // Round-robin pick.
    // The scan starts one past the last served requester and wraps
    // modulo N_REQ, so the requester just served is considered last.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Operand mux for the winner; a constant-index loop keeps slicing simple.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_a = op_a[i*W +: W];
                sel_b = op_b[i*W +: W];
            end
        end
    end

    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_oh[i] = (idx_q == IW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        m_a_d   = m_a_q;
        m_b_d   = m_b_q;
        res_d   = res_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Operands are captured here once; later op_a/op_b
                // changes cannot reach the in-flight product.
                if (found) begin
                    idx_d   = win;
                    m_a_d   = sel_a;
                    m_b_d   = sel_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // m_rdy is deliberately ignored in the load cycle.
                state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (m_rdy) begin
                    // A ready on the final allowed cycle still wins.
                    res_d   = m_res;
                    state_d = S_DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles. The value TIMEOUT-1
                // therefore marks the TIMEOUT-th WAIT cycle.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            m_a_q   <= '0;
            m_b_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            m_a_q   <= m_a_d;
            m_b_q   <= m_b_d;
            res_q   <= res_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state
    // ------------------------------------------------------------------
    assign gnt  = (state_q != S_IDLE) ? idx_oh : '0;
    assign done = (state_q == S_DONE) ? idx_oh : '0;
    assign m_ld = (state_q == S_LOAD);
    assign busy = (state_q != S_IDLE);
    assign res  = res_q;
    assign m_a  = m_a_q;
    assign m_b  = m_b_q;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single sequential 8x8 multiplier between up to four requesters, such as colour-channel scaling and intensity scaling paths.
- Latches the winner's operands, pulses the multiplier load, waits for its ready, then returns the 16-bit product with a one-cycle done strobe.
- Sits between the multiplier and its clients, on the system clock.

Parameters:
- N_REQ, 4, number of requesters (supported range 2..4).
- W, 8, operand width; product width is 2*W.
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only when the optional feature is enabled).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- op_a  in  N_REQ*W  packed operand A; requester i uses bits [i*W +: W].
- op_b  in  N_REQ*W  packed operand B, same packing as op_a.
- gnt  out  N_REQ  one-hot; high from LOAD through DONE for the served requester.
- done  out  N_REQ  one-cycle pulse to the served requester; res is valid in that cycle.
- res  out  2*W  product, held until the next capture.
- busy  out  1  high in any state other than IDLE.
- m_ld  out  1  multiplier load pulse.
- m_a  out  W  multiplier operand A, stable from LOAD until return to IDLE.
- m_b  out  W  multiplier operand B, same stability rule as m_a.
- m_res  in  2*W  multiplier result.
- m_rdy  in  1  multiplier result-valid.
- err  out  1  timeout flag; present only with MULT_ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; gnt, done, res, m_ld, m_a, m_b, busy, err all 0.
  - last pointer = N_REQ-1, so requester 0 has first priority after reset.
- FSM: IDLE -> LOAD -> WAIT -> DONE -> IDLE.
- IDLE:
  - If req != 0, select the first set bit scanning last+1, last+2, ... modulo N_REQ.
  - Register the winner index; latch m_a/m_b from its op_a/op_b slices.
  - Go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD (exactly one cycle):
  - m_ld=1, gnt[idx]=1, busy=1.
  - Go to WAIT.
  - m_rdy is ignored in this cycle.
- WAIT:
  - m_ld=0.
  - When m_rdy=1: res <= m_res, go to DONE.
  - Otherwise stay in WAIT.
- DONE (one cycle):
  - done[idx]=1 while gnt[idx] is still 1.
  - last <= idx.
  - Go to IDLE; gnt clears on the exit edge.
- Latency:
  - req sampled in IDLE at edge 0 -> m_ld/gnt high in cycle 1.
  - Mult ready at WAIT cycle k -> done at cycle k+1.
  - Arbiter overhead: 3 cycles plus multiplier time.
- Operand stability:
  - Operands are captured once in IDLE.
  - Later changes on op_a/op_b never affect an in-flight product.
- req dropped while granted: the transaction completes and done still pulses; the result is simply unused.
- req held after done: the requester is eligible again, but round-robin order places it last among the active requesters.
- Simultaneous requests: strict rotation; no requester waits more than N_REQ-1 transactions.
- m_rdy in IDLE, LOAD or DONE: ignored; no state change.
- Reset mid-transaction: immediate return to reset values; any pending product is discarded and done is not pulsed.
- Only one transaction is ever in flight; m_ld never re-pulses before DONE.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without m_rdy: res <= 0, err <= 1 (sticky until reset), go to DONE, done pulses normally.
  - If m_rdy and the timeout coincide, m_rdy wins: no error, product captured.
- When undefined:
  - No counter and no err port.
  - WAIT waits indefinitely for m_rdy.

Test Plan:
- Bench multiplier model asserts m_rdy 8 cycles after m_ld.
- req[0] with op_a=0x0F, op_b=0x11 -> m_ld one cycle, gnt=0001 throughout, done[0] pulse with res=0x00FF, busy low afterwards.
- All four req high from reset, operand pairs (2,3), (4,5), (6,7), (0xFF,0xFF) -> done order 0,1,2,3, results 0x0006, 0x0014, 0x002A, 0xFE01; no gap beyond 3 cycles of overhead each.
- Fairness: after serving req1, req0 and req2 both high -> req2 served before req0.
- op_a changed from 0x10 to 0x20 during WAIT, op_b=0x02 -> res=0x0020, proving operands were latched.
- reset pulsed low during WAIT -> gnt=0, no done, busy=0; the next request is served from requester 0 first.
- MULT_ARB_TIMEOUT_EN with TIMEOUT=64 and model never asserting m_rdy -> done after 64 WAIT cycles, res=0x0000, err=1 held until reset; separately, m_rdy arriving on the 64th cycle -> correct product, err=0.
